// File: rtl/mips32_dmem_responder.sv
// Word-addressed data-memory slave for the MIPS32 core: one outstanding LW/SW
// over valid/ready request and response channels, with a fixed number of wait states.
module mips32_dmem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t                state, state_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic                  req_ready_nxt;
   logic                  rsp_valid_nxt;
   logic                  rsp_err_nxt;
   logic [DATA_WIDTH-1:0] rsp_rdata_nxt;

   logic                  lat_load;
   logic                  lat_we;
   logic [31:0]           lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;

   logic                  do_access;
   logic                  acc_we;
   logic [31:0]           acc_addr;
   logic [DATA_WIDTH-1:0] acc_wdata;
   logic                  addr_ok;
   logic [ADDR_WIDTH-1:0] acc_idx;
   logic [DATA_WIDTH-1:0] rd_word;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // With zero wait states the access happens on the accept edge itself,
   // so it must use the live request rather than the latched copy.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      req_ready_nxt = req_ready;
      rsp_valid_nxt = rsp_valid;
      rsp_err_nxt   = rsp_err;
      rsp_rdata_nxt = rsp_rdata;
      lat_load      = 1'b0;
      do_access     = 1'b0;
      acc_we        = lat_we;
      acc_addr      = lat_addr;
      acc_wdata     = lat_wdata;

      case (state)
         IDLE: begin
            if (!req_ready) begin
               req_ready_nxt = 1'b1;
            end else if (req_valid) begin
               lat_load      = 1'b1;
               req_ready_nxt = 1'b0;
               if (WAIT_STATES == 0) begin
                  do_access = 1'b1;
                  acc_we    = req_we;
                  acc_addr  = req_addr;
                  acc_wdata = req_wdata;
                  state_nxt = RESP;
               end else begin
                  cnt_nxt   = CNT_LOAD;
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               do_access = 1'b1;
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               req_ready_nxt = 1'b1;
               state_nxt     = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (do_access) begin
         rsp_valid_nxt = 1'b1;
         rsp_err_nxt   = !addr_ok;
         rsp_rdata_nxt = (acc_we || !addr_ok) ? '0 : rd_word;
      end
   end

   assign addr_ok = ((acc_addr >> ADDR_WIDTH) == 32'd0);
   assign acc_idx = acc_addr[ADDR_WIDTH-1:0];
   assign rd_word = mem[acc_idx];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         req_ready <= req_ready_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_err   <= rsp_err_nxt;
         rsp_rdata <= rsp_rdata_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (lat_load) begin
         lat_we    <= req_we;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
      end
   end

   // Storage is never cleared; a reset coinciding with the access edge cancels the store.
   always_ff @(posedge clk) begin
      if (rst_n && do_access && acc_we && addr_ok) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

endmodule
